// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// Provides flush, x0-write gating and saturating stall/bubble counters.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SRC_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [SRC_W-1:0]  in_reg_src,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic [DATA_W-1:0] in_alu_rlt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_pc_4,
  input  logic [DATA_W-1:0] in_pc_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [SRC_W-1:0]  out_reg_src,
  output logic [DATA_W-1:0] out_load_data,
  output logic [DATA_W-1:0] out_alu_rlt,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_pc_4,
  output logic [DATA_W-1:0] out_pc_imm,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              reg_write;
    logic [SRC_W-1:0]  reg_src;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] alu_rlt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] pc_4;
    logic [DATA_W-1:0] pc_imm;
  } ent_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t in_ent;
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic rdy_q, rdy_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic acc;
  logic main_ld;

  assign in_ent = '{
    reg_write: in_reg_write,
    reg_src:   in_reg_src,
    load_data: in_load_data,
    alu_rlt:   in_alu_rlt,
    rd:        in_rd,
    pc_4:      in_pc_4,
    pc_imm:    in_pc_imm
  };

  assign acc     = in_valid & rdy_q;
  assign main_ld = ~main_v_q | out_ready;

  // Entry movement: skid has priority into main, input fills whichever slot is free.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (main_ld) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          main_v_d = 1'b1;
          skid_v_d = 1'b0;
        end else if (acc) begin
          main_d   = in_ent;
          main_v_d = 1'b1;
        end else begin
          main_v_d = 1'b0;
        end
      end
      if (acc & main_v_q & ~out_ready) begin
        skid_d   = in_ent;
        skid_v_d = 1'b1;
      end
    end
    rdy_d = ~skid_v_d;
  end

  // Saturating stall/bubble counters, observed on the current WB handshake.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_v_q & ~out_ready & (stall_q != CNT_MAX))
      stall_d = stall_q + CNT_ONE;
    if (~main_v_q & out_ready & (bubble_q != CNT_MAX))
      bubble_d = bubble_q + CNT_ONE;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = main_v_q;
  assign out_reg_write = main_q.reg_write & main_v_q & (main_q.rd != '0);
  assign out_reg_src   = main_q.reg_src;
  assign out_load_data = main_q.load_data;
  assign out_alu_rlt   = main_q.alu_rlt;
  assign out_rd        = main_q.rd;
  assign out_pc_4      = main_q.pc_4;
  assign out_pc_imm    = main_q.pc_imm;
  assign stall_cnt     = stall_q;
  assign bubble_cnt    = bubble_q;

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline stage. Supersedes the fixed-width hold-on-hazard register.
- Replaces the single global stall with a valid/ready handshake on both sides and a 2-entry skid buffer, so the upstream ready path is fully registered.
- Adds synchronous flush, x0-write suppression and saturating stall/bubble performance counters.
- Sits between the MEM stage and the register-file writeback mux.

Parameters:
- DATA_W, 32, width of load data, ALU result, pc+4 and pc+imm.
- REG_AW, 5, destination register address width.
- SRC_W, 2, writeback-source select width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  MEM-side entry valid.
- in_ready  out  1  stage can accept an entry; registered.
- in_reg_write  in  1  register-file write enable.
- in_reg_src  in  SRC_W  writeback source select.
- in_load_data  in  DATA_W  data-memory read data.
- in_alu_rlt  in  DATA_W  ALU result.
- in_rd  in  REG_AW  destination register.
- in_pc_4  in  DATA_W  pc+4.
- in_pc_imm  in  DATA_W  pc+imm.
- out_valid  out  1  WB-side entry valid.
- out_ready  in  1  WB consumes the entry.
- out_reg_write  out  1  gated write enable.
- out_reg_src  out  SRC_W  held select.
- out_load_data  out  DATA_W  held load data.
- out_alu_rlt  out  DATA_W  held ALU result.
- out_rd  out  REG_AW  held destination register.
- out_pc_4  out  DATA_W  held pc+4.
- out_pc_imm  out  DATA_W  held pc+imm.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry holds all payload fields plus a valid bit.
- Handshakes:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (pop) = out_valid & out_ready.
- in_ready = ~skid_valid, as a flop.
- Main entry load: main loads when ~main_valid | out_ready.
  - Source is the skid entry if skid_valid, else the input if acc.
  - Otherwise main_valid clears.
- Skid entry fill: skid captures the input when acc & main_valid & ~out_ready.
- Skid entry release: skid clears when main loads from it.
- Latency: an entry accepted at edge N is visible on out_* after edge N when the stage was empty. Throughput is 1 entry/cycle with out_ready held high.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- Capacity 2. in_ready=0 while skid_valid=1. in_valid with in_ready=0 has no effect.
- out_reg_write = main.reg_write & main_valid & (main.rd != 0).
- Payload outputs hold their last value while out_valid=0. Nothing is zeroed on pop.
- Flush:
  - Next edge: main_valid=0, skid_valid=0, in_ready=1.
  - An input presented in the flush cycle is discarded.
  - Payload registers are retained.
  - Counters are unaffected.
- Priority: rst > flush > normal operation.
- Reset: every payload output 0, out_valid=0, out_reg_write=0, in_ready=1, stall_cnt=0, bubble_cnt=0. Reset mid-transfer discards both entries.
- Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W-1. No wrap.
- Simultaneous pop and acc with skid empty: main takes the input, skid stays empty.
- Simultaneous pop and acc with skid full: cannot occur, since in_ready=0.

Test Plan:
- Streaming: out_ready=1, 4 entries rd=1..4 with alu_rlt=0x10..0x13 on consecutive cycles -> out_valid asserted 1 cycle after each accept; rd 1,2,3,4 in order; zero bubbles after the first; stall_cnt=0.
- Backpressure: out_ready=0 with 3 entries offered -> in_ready=0 after 2 accepts; out_rd stays 1. Then raise out_ready -> rd 1,2 drain, then 3 is accepted. stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- x0 suppression: entry rd=0, reg_write=1, alu_rlt=0xDEADBEEF -> out_valid=1, out_reg_write=0, out_alu_rlt=0xDEADBEEF.
- Flush while full: both entries held, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle input never appears on out_*.
- Reset mid-operation: both entries full, counters nonzero, then rst=1 -> next cycle all outputs 0, in_ready=1, counters 0.
- Saturation: CNT_W=4, out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 and holds at 15.
